// File: rtl/tea_pkg.sv
// rtl/tea_pkg.sv - shared TEA constants, state encoding and round helper functions
//
// Purpose: common definitions for the iterative TEA sequencer and its round datapath.
//   DELTA         TEA key-schedule constant
//   state_t       sequencer states IDLE / RUN / DONE
//   tea_f         TEA mixing function F(x,s,a,b)
//   tea_dec_sum0  starting sum for decryption, DELTA*rounds mod 2^32
package tea_pkg;

  localparam logic [31:0] DELTA = 32'h9E37_79B9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // F(x,s,a,b) = ((x<<4)+a) ^ (x+s) ^ ((x>>5)+b), all mod 2^32, logical shift
  function automatic logic [31:0] tea_f(input logic [31:0] x, input logic [31:0] s,
                                        input logic [31:0] a, input logic [31:0] b);
    return ((x << 4) + a) ^ (x + s) ^ ((x >> 5) + b);
  endfunction

  // 32-bit product truncates naturally to the mod 2^32 result
  function automatic logic [31:0] tea_dec_sum0(input int unsigned rounds);
    return DELTA * rounds;
  endfunction

endpackage

// File: rtl/tea_round.sv
// rtl/tea_round.sv - combinational single TEA cycle (both half-rounds) for encrypt or decrypt
//
// Purpose: one full TEA cycle per evaluation, shared by encrypt and decrypt.
// Ports:
//   i_v0, i_v1   in  32   current block halves
//   i_sum        in  32   running sum before this cycle
//   i_key        in  128  k0=[127:96] k1=[95:64] k2=[63:32] k3=[31:0]
//   i_encrypt    in  1    1 = encrypt cycle, 0 = decrypt cycle
//   o_v0, o_v1   out 32   block halves after this cycle
//   o_sum        out 32   running sum after this cycle
module tea_round (
  input  logic [31:0]  i_v0,
  input  logic [31:0]  i_v1,
  input  logic [31:0]  i_sum,
  input  logic [127:0] i_key,
  input  logic         i_encrypt,
  output logic [31:0]  o_v0,
  output logic [31:0]  o_v1,
  output logic [31:0]  o_sum
);
  import tea_pkg::*;

  logic [31:0] w_k0, w_k1, w_k2, w_k3;
  logic [31:0] w_s_enc;
  logic [31:0] w_v0_enc, w_v1_enc;
  logic [31:0] w_v0_dec, w_v1_dec;

  assign w_k0 = i_key[127:96];
  assign w_k1 = i_key[95:64];
  assign w_k2 = i_key[63:32];
  assign w_k3 = i_key[31:0];

  // Encrypt: advance sum first, then v0 and v1 in sequence (v1 uses new v0)
  assign w_s_enc  = i_sum + DELTA;
  assign w_v0_enc = i_v0 + tea_f(i_v1, w_s_enc, w_k0, w_k1);
  assign w_v1_enc = i_v1 + tea_f(w_v0_enc, w_s_enc, w_k2, w_k3);

  // Decrypt: exact inverse order, v1 undone first with the current sum
  assign w_v1_dec = i_v1 - tea_f(i_v0, i_sum, w_k2, w_k3);
  assign w_v0_dec = i_v0 - tea_f(w_v1_dec, i_sum, w_k0, w_k1);

  assign o_v0  = i_encrypt ? w_v0_enc : w_v0_dec;
  assign o_v1  = i_encrypt ? w_v1_enc : w_v1_dec;
  assign o_sum = i_encrypt ? w_s_enc  : (i_sum - DELTA);

endmodule

// File: rtl/tea_iter_sequencer.sv
// rtl/tea_iter_sequencer.sv - iterative TEA engine: handshake, FSM and state around one shared round
//
// Purpose: accepts one block+key+mode, runs tea_round once per enabled cycle for ROUNDS cycles,
//   then presents the result until taken. One block in flight.
// Optional feature macro: TEA_ABORT_EN adds the abort input (cancel a block in RUN or DONE).
// Ports:
//   clk         in   1    clock, rising edge
//   rst         in   1    synchronous active-high reset, dominates ena
//   ena         in   1    clock enable; 0 freezes all state and forces in_ready low
//   abort       in   1    (TEA_ABORT_EN only) drop block in flight, clear result
//   in_valid    in   1    request valid
//   in_ready    out  1    ena & IDLE
//   encrypt     in   1    1 = encrypt, 0 = decrypt, sampled on accept
//   inBlock64   in   64   v0=[63:32] v1=[31:0], sampled on accept
//   key         in   128  k0..k3 high to low, sampled on accept
//   out_valid   out  1    result valid, held until taken
//   out_ready   in   1    consumer ready
//   outBlock64  out  64   {v0,v1} result, stable while out_valid
//   busy        out  1    RUN or DONE
module tea_iter_sequencer #(
  parameter int unsigned ROUNDS = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
`ifdef TEA_ABORT_EN
  input  logic         abort,
`endif
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         encrypt,
  input  logic [63:0]  inBlock64,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [63:0]  outBlock64,
  output logic         busy
);
  import tea_pkg::*;

  localparam logic [7:0]  LP_LAST     = 8'(ROUNDS - 1);
  localparam logic [31:0] LP_DEC_SUM0 = tea_dec_sum0(ROUNDS);

  state_t        r_state, w_state_next;
  logic [7:0]    r_cnt;
  logic [31:0]   r_v0, r_v1, r_sum;
  logic [127:0]  r_key;
  logic          r_enc;
  logic [63:0]   r_out;

  logic [31:0]   w_v0n, w_v1n, w_sumn;
  logic          w_accept;
  logic          w_last;
  logic          w_abort;

  tea_round u_round (
    .i_v0      (r_v0),
    .i_v1      (r_v1),
    .i_sum     (r_sum),
    .i_key     (r_key),
    .i_encrypt (r_enc),
    .o_v0      (w_v0n),
    .o_v1      (w_v1n),
    .o_sum     (w_sumn)
  );

  assign in_ready   = ena & (r_state == IDLE);
  assign w_accept   = in_ready & in_valid;
  assign w_last     = (r_cnt == LP_LAST);
  assign out_valid  = (r_state == DONE);
  assign busy       = (r_state != IDLE);
  assign outBlock64 = r_out;

  // Abort only matters once a block is in flight, so accept always wins in IDLE
`ifdef TEA_ABORT_EN
  assign w_abort = ena & abort & (r_state != IDLE);
`else
  assign w_abort = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) w_state_next = RUN;
      end
      RUN: begin
        if (w_abort)           w_state_next = IDLE;
        else if (ena && w_last) w_state_next = DONE;
      end
      DONE: begin
        if (w_abort)                w_state_next = IDLE;
        else if (ena && out_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_v0  <= '0;
      r_v1  <= '0;
      r_sum <= '0;
      r_key <= '0;
      r_enc <= 1'b0;
      r_out <= '0;
    end else if (ena) begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_v0  <= inBlock64[63:32];
            r_v1  <= inBlock64[31:0];
            r_key <= key;
            r_enc <= encrypt;
            r_sum <= encrypt ? 32'h0 : LP_DEC_SUM0;
            r_cnt <= '0;
          end
        end
        RUN: begin
          if (w_abort) begin
            r_out <= '0;
          end else begin
            r_v0  <= w_v0n;
            r_v1  <= w_v1n;
            r_sum <= w_sumn;
            r_cnt <= r_cnt + 8'd1;
            // Result register loads only on the final cycle so it stays stable through DONE
            if (w_last) r_out <= {w_v0n, w_v1n};
          end
        end
        DONE: begin
          if (w_abort) r_out <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tea_iter_sequencer.sv
// tb/tb_tea_iter_sequencer.sv - directed self-checking bench for tea_iter_sequencer
module tb_tea_iter_sequencer;

  localparam logic [31:0] D = 32'h9E37_79B9;

  logic         clk = 1'b0;
  logic         rst, ena, in_valid, encrypt, out_ready;
  logic [63:0]  inBlock64;
  logic [127:0] key;
  logic         in_ready, out_valid, busy;
  logic [63:0]  outBlock64;
`ifdef TEA_ABORT_EN
  logic         abort;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  tea_iter_sequencer dut (
`ifdef TEA_ABORT_EN
    .abort      (abort),
`endif
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .encrypt    (encrypt),
    .inBlock64  (inBlock64),
    .key        (key),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .outBlock64 (outBlock64),
    .busy       (busy)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Textbook 32-cycle TEA, written as plain loops
  function automatic logic [63:0] ref_tea(input logic enc, input logic [63:0] blk,
                                          input logic [127:0] k);
    logic [31:0] y, z, sum;
    y = blk[63:32];
    z = blk[31:0];
    if (enc) begin
      sum = 32'h0;
      for (int i = 0; i < 32; i++) begin
        sum = sum + D;
        y = y + (((z << 4) + k[127:96]) ^ (z + sum) ^ ((z >> 5) + k[95:64]));
        z = z + (((y << 4) + k[63:32]) ^ (y + sum) ^ ((y >> 5) + k[31:0]));
      end
    end else begin
      sum = 32'hC6EF_3720;
      for (int i = 0; i < 32; i++) begin
        z = z - (((y << 4) + k[63:32]) ^ (y + sum) ^ ((y >> 5) + k[31:0]));
        y = y - (((z << 4) + k[127:96]) ^ (z + sum) ^ ((z >> 5) + k[95:64]));
        sum = sum - D;
      end
    end
    return {y, z};
  endfunction

  // Presents one request; returns at the negedge of the cycle after acceptance (latency 1)
  task automatic launch(input logic enc, input logic [63:0] blk, input logic [127:0] k);
    @(negedge clk);
    check_eq("in_ready_before_accept", in_ready, 1);
    encrypt = enc; inBlock64 = blk; key = k; in_valid = 1;
    @(negedge clk);
    in_valid = 0; encrypt = ~enc; inBlock64 = ~blk; key = ~k;
  endtask

  task automatic wait_out(input int start, output int lat);
    lat = start;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic take(input string tag);
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    check_eq({tag, "_valid_after_take"}, out_valid, 0);
    check_eq({tag, "_busy_after_take"}, busy, 0);
  endtask

  task automatic run_and_check(input string tag, input logic enc, input logic [63:0] blk,
                               input logic [127:0] k, input logic [63:0] exp);
    int lat;
    launch(enc, blk, k);
    wait_out(1, lat);
    check_eq({tag, "_latency"}, 64'(lat), 64'd33);
    check_eq({tag, "_result"}, outBlock64, exp);
    take(tag);
  endtask

  logic [63:0]  blks [3] = '{64'h0123_4567_89AB_CDEF, 64'hFFFF_FFFF_0000_0001, 64'hDEAD_BEEF_CAFE_F00D};
  logic [127:0] keys [3] = '{128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF,
                             128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF,
                             128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210};

  initial begin
    int lat;
    logic [63:0] exp, ct;

    rst = 1; ena = 1; in_valid = 0; out_ready = 0; encrypt = 0; inBlock64 = '0; key = '0;
`ifdef TEA_ABORT_EN
    abort = 0;
`endif
    repeat (2) @(negedge clk);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_out_block", outBlock64, 0);
    check_eq("rst_in_ready", in_ready, 1);
    ena = 0;
    #1 check_eq("in_ready_ena_low", in_ready, 0);
    ena = 1;
    rst = 0;

    // Known-answer vectors
    run_and_check("enc_zero", 1, 64'h0, 128'h0, 64'h41EA_3A0A_94BA_A940);
    run_and_check("dec_zero", 0, 64'h41EA_3A0A_94BA_A940, 128'h0, 64'h0);

    // Round trips against the reference model
    for (int i = 0; i < 3; i++) begin
      ct = ref_tea(1, blks[i], keys[i]);
      run_and_check($sformatf("enc_vec%0d", i), 1, blks[i], keys[i], ct);
      run_and_check($sformatf("dec_vec%0d", i), 0, ct, keys[i], blks[i]);
    end

    // Consumer stalls in DONE; new requests must be ignored
    exp = ref_tea(1, blks[0], keys[1]);
    launch(1, blks[0], keys[1]);
    wait_out(1, lat);
    in_valid = 1; inBlock64 = 64'h5555_AAAA_5555_AAAA; encrypt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("stall_out_valid", out_valid, 1);
      check_eq("stall_out_block", outBlock64, exp);
      check_eq("stall_in_ready", in_ready, 0);
    end
    in_valid = 0;
    take("stall");

    // Clock enable low for 5 cycles mid-RUN delays completion by exactly 5
    exp = ref_tea(0, blks[2], keys[2]);
    launch(0, blks[2], keys[2]);
    repeat (9) @(negedge clk);
    ena = 0;
    repeat (5) begin
      @(negedge clk);
      check_eq("ena_low_busy", busy, 1);
    end
    ena = 1;
    wait_out(15, lat);
    check_eq("ena_gap_latency", 64'(lat), 64'd38);
    check_eq("ena_gap_result", outBlock64, exp);
    // ena low in DONE: out_ready is ignored
    ena = 0; out_ready = 1;
    @(negedge clk);
    check_eq("ena_low_done_hold", out_valid, 1);
    check_eq("ena_low_done_block", outBlock64, exp);
    ena = 1;
    take("ena_gap");

    // Reset at RUN round 10
    launch(1, blks[1], keys[0]);
    repeat (10) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check_eq("rst_run_out_valid", out_valid, 0);
    check_eq("rst_run_in_ready", in_ready, 1);
    check_eq("rst_run_busy", busy, 0);
    run_and_check("after_rst", 1, blks[2], keys[0], ref_tea(1, blks[2], keys[0]));

    // Reset in DONE clears the held result
    launch(1, blks[1], keys[2]);
    wait_out(1, lat);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check_eq("rst_done_out_valid", out_valid, 0);
    check_eq("rst_done_out_block", outBlock64, 0);

`ifdef TEA_ABORT_EN
    launch(1, blks[1], keys[0]);
    repeat (10) @(negedge clk);
    abort = 1;
    @(negedge clk);
    abort = 0;
    check_eq("abort_run_out_valid", out_valid, 0);
    check_eq("abort_run_in_ready", in_ready, 1);
    check_eq("abort_run_busy", busy, 0);
    run_and_check("after_abort", 1, blks[2], keys[0], ref_tea(1, blks[2], keys[0]));

    launch(1, blks[0], keys[0]);
    wait_out(1, lat);
    abort = 1;
    @(negedge clk);
    abort = 0;
    check_eq("abort_done_out_valid", out_valid, 0);
    check_eq("abort_done_out_block", outBlock64, 0);

    // Abort asserted during the accept cycle: accept wins
    @(negedge clk);
    encrypt = 1; inBlock64 = blks[1]; key = keys[1]; in_valid = 1; abort = 1;
    @(negedge clk);
    in_valid = 0; abort = 0;
    wait_out(1, lat);
    check_eq("abort_accept_latency", 64'(lat), 64'd33);
    check_eq("abort_accept_result", outBlock64, ref_tea(1, blks[1], keys[1]));
    take("abort_accept");
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
